// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_vram_arbiter
// Purpose  : Shares a single-port 320x240x8 VRAM between video scan-out, which
//            always has priority, and a CPU request/ack port. A CPU request
//            that collides with a video slot is retried on the next cycle.
// Config   : define VGA_VRAM_CPU_READ_EN to allow CPU reads of VRAM.
// Revision : 1.0 - initial release
// ============================================================================
module vga_vram_arbiter (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  xpos,
  input  logic [9:0]  ypos,
  input  logic        vid_active,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [16:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel
);

  localparam logic [16:0] C_FB_BYTES = 17'd76800;
`ifdef VGA_VRAM_CPU_READ_EN
  localparam logic C_READ_EN = 1'b1;
`else
  localparam logic C_READ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_cpu_ack;
  logic [7:0]  r_cpu_rdata;
  logic [7:0]  r_pixel;
  logic        r_vid_fetch;

  logic        w_slot;
  logic [16:0] w_src_y;
  logic [16:0] w_vid_addr;
  logic        w_in_range;
  logic        w_needs_mem;
  logic        w_start;
  logic        w_unused;

  assign w_slot     = pix_en & vid_active & ~xpos[0];
  assign w_src_y    = {8'd0, ypos[9:1]};
  // (y/2)*320 = (y/2)*256 + (y/2)*64
  assign w_vid_addr = (w_src_y << 8) + (w_src_y << 6) + {8'd0, xpos[9:1]};
  assign w_in_range = (cpu_addr < C_FB_BYTES);
  // Reads need no memory cycle when CPU read-back is disabled, so they never wait
  assign w_needs_mem = cpu_we | C_READ_EN;
  assign w_start     = (r_state == S_IDLE) & cpu_req & ~(w_slot & w_needs_mem);
  assign w_unused    = ypos[0];

  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign pixel     = r_pixel;

  always_comb begin
    mem_addr  = 17'd0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (!reset) begin
      if (w_slot) begin
        mem_addr = w_vid_addr;
      end else if (w_start && w_needs_mem) begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we & w_in_range;
        mem_wdata = cpu_we ? cpu_wdata : 8'h00;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 8'h00;
      r_pixel     <= 8'h00;
      r_vid_fetch <= 1'b0;
    end else begin
      r_vid_fetch <= w_slot;
      if (r_vid_fetch) begin
        r_pixel <= mem_rdata;
      end else if (pix_en && !vid_active) begin
        r_pixel <= 8'h00;
      end

      r_cpu_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!cpu_we) begin
            r_cpu_rdata <= (C_READ_EN && w_in_range) ? mem_rdata : 8'h00;
          end
          r_cpu_ack <= 1'b1;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 SHALL have ports CLK_50M in 1 (system clock) and reset in 1 (synchronous, active-high); one clock only.
REQ-002 SHALL have pix_en in 1: 25 MHz pixel enable, high every other CLK_50M cycle.
REQ-003 SHALL have xpos in 10 and ypos in 10: current pixel position, both 0 outside the visible area.
REQ-004 SHALL have vid_active in 1: high while the scan is inside the 640x480 visible area.
REQ-005 SHALL have cpu_req in 1, cpu_we in 1, cpu_addr in 17 and cpu_wdata in 8: CPU request, write flag, address and write data.
REQ-006 SHALL have cpu_ack out 1 and cpu_rdata out 8: one-cycle completion strobe and read data.
REQ-007 SHALL have mem_addr out 17, mem_we out 1 and mem_wdata out 8: VRAM port driven combinationally from state and inputs.
REQ-008 SHALL have mem_rdata in 8: VRAM synchronous read data, valid the cycle after the address.
REQ-009 SHALL have pixel out 8: registered 8-bit colour index for scan-out.

Function
REQ-010 SHALL treat the framebuffer as 320x240 at 8 bpp (76800 bytes), each source pixel shown as 2x2 screen pixels.
REQ-011 SHALL define the video slot as pix_en & vid_active & ~xpos[0].
REQ-012 In a video slot SHALL drive mem_addr = (ypos>>1)*320 + (xpos>>1), computed as shifts and adds in 17 bits, with mem_we=0.
REQ-013 SHALL load pixel from mem_rdata in the cycle after each video slot and hold it otherwise.
REQ-014 SHALL load pixel with 0x00 on any pix_en cycle with vid_active=0.
REQ-015 SHALL always give the video slot priority; a video fetch is never delayed or skipped.
REQ-016 SHALL run a CPU state machine IDLE -> ISSUE -> ACK -> IDLE.
REQ-017 IDLE: SHALL stay in IDLE while cpu_req=0.
REQ-018 IDLE: when cpu_req=1 in a non-video-slot cycle, SHALL drive cpu_addr on mem_addr (and on a write, cpu_wdata with mem_we=1) that same cycle, then go to ISSUE.
REQ-019 IDLE: when cpu_req=1 in a video-slot cycle, SHALL stay in IDLE and retry the next cycle.
REQ-020 ISSUE: SHALL capture mem_rdata into cpu_rdata on a read, leave cpu_rdata unchanged on a write, and go to ACK.
REQ-021 ACK: SHALL assert cpu_ack for exactly one cycle, ignore cpu_req, and return to IDLE.
REQ-022 SHALL give CPU latency of 2 cycles from request to ack when uncontested and 3 cycles on a video-slot collision.
REQ-023 SHALL require the requester to hold cpu_req, cpu_we, cpu_addr and cpu_wdata stable until cpu_ack and to drop cpu_req the cycle after cpu_ack.
REQ-024 SHALL suppress mem_we for cpu_addr >= 76800, still complete the transaction with normal ack timing, and return cpu_rdata=0x00 on such a read.
REQ-025 SHALL hold mem_we=0 in every cycle other than a CPU write issue cycle.
REQ-026 SHALL set mem_addr=0 and mem_wdata=0 when the port is idle.

Reset
REQ-027 On reset SHALL set the state to IDLE, cpu_ack=0, cpu_rdata=0x00, pixel=0x00 and mem_we=0.
REQ-028 SHALL abandon any in-flight CPU transaction on reset without issuing cpu_ack; reset overrides all inputs.

Configuration
REQ-029 SHALL provide macro VGA_VRAM_CPU_READ_EN.
REQ-030 With VGA_VRAM_CPU_READ_EN defined, SHALL perform CPU reads as in REQ-018..REQ-022.
REQ-031 Without VGA_VRAM_CPU_READ_EN, SHALL issue no memory cycle for a cpu_we=0 request, still ack it at the normal 2-cycle latency, hold cpu_rdata at 0x00, and leave writes unchanged.

Verification
REQ-032 Reset test: reset high 2 cycles with cpu_req=1, cpu_we=1 -> cpu_ack=0, pixel=0x00, mem_we=0 throughout, and no ack after reset release until a new request.
REQ-033 Blank-area write: vid_active=0; cpu_req=1, we=1, addr=0x00140, data=0xA5 at cycle 0 -> mem_we=1, mem_addr=0x00140, mem_wdata=0xA5 in cycle 0 only; cpu_ack=1 in cycle 2 only.
REQ-034 Video fetch: vid_active=1, xpos=10, ypos=7, pix_en=1 -> mem_addr=965, mem_we=0; mem_rdata=0x3C next cycle -> pixel=0x3C from the following cycle, held through xpos=11.
REQ-035 Collision: cpu_req=1, we=0, addr=0x12345 rises in a video-slot cycle -> video address is driven that cycle, the CPU address the next cycle; with VGA_VRAM_CPU_READ_EN, cpu_rdata equals mem_rdata and cpu_ack arrives at +3 cycles.
REQ-036 Out-of-range write: write to addr 76800 -> mem_we stays 0 and cpu_ack arrives at +2 cycles; a read of 76800 returns cpu_rdata=0x00.
REQ-037 Macro off: build without VGA_VRAM_CPU_READ_EN; read request -> no mem_addr change and cpu_ack at +2 cycles with cpu_rdata=0x00.
